fifo_tree_drain: RTL and testbench

- Consumer end of the clause FIFO tree: pops unsatisfied clauses one per cycle and presents them downstream over a valid/ready handshake through a 2-entry skid buffer.
- Detects end of batch (write side finished and tree quiet), counts clauses delivered, and reports sat / overflow.
- On tree overflow, flushes the tree and pulses the clear-overflow line.
- Sits between FIFO_tree and the WalkSAT clause-select / variable-pick stage.

---
 rtl/fifo_tree_drain.sv | 155 +++++++++++++++
 tb/tb_fifo_tree_drain.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tree_drain.sv
// Consumer end of the clause FIFO tree. It pops clauses from the tree and
// delivers them downstream through a 2-entry skid buffer. It also detects the
// end of a batch, counts the delivered clauses, and flushes the tree on overflow.
module fifo_tree_drain #(
  parameter int unsigned CLAUSE_WIDTH  = 36,
  parameter int unsigned COUNT_WIDTH   = 10,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    write_done_i,
  input  logic                    fifo_empty_i,
  input  logic [CLAUSE_WIDTH-1:0] fifo_clause_i,
  input  logic                    fifo_of_i,
  output logic                    fifo_rden_o,
  output logic                    fifo_cof_o,
  output logic [CLAUSE_WIDTH-1:0] clause_o,
  output logic                    clause_valid_o,
  input  logic                    clause_ready_i,
  output logic                    batch_done_o,
  output logic [COUNT_WIDTH-1:0]  unsat_count_o,
  output logic                    sat_o,
  output logic                    overflow_o
);

  localparam int unsigned QuietWidth = $clog2(SETTLE_CYCLES + 1);
  localparam logic [QuietWidth-1:0] QuietLast = QuietWidth'(SETTLE_CYCLES - 1);
  localparam logic [QuietWidth-1:0] QuietMax  = QuietWidth'(SETTLE_CYCLES);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StFinish = 2'd2;
  localparam logic [1:0] StFlush  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [1:0]              occ_q, occ_d;
  logic [CLAUSE_WIDTH-1:0] head_q, head_d;
  logic [CLAUSE_WIDTH-1:0] tail_q, tail_d;
  logic                    inflight_q, inflight_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic                    wd_seen_q, wd_seen_d;
  logic [QuietWidth-1:0]   quiet_q, quiet_d;

  logic       pop;
  logic [1:0] occ_after;
  logic [1:0] committed;
  logic       wd_eff;
  logic       quiet_cond;
  logic       settled;
  logic [QuietWidth-1:0] quiet_inc;

  assign clause_o      = head_q;
  assign unsat_count_o = count_q;

  // Handshake, read-issue and quiet-detection terms shared by the next-state logic.
  always_comb begin
    clause_valid_o = (occ_q != 2'd0) && (state_q != StFlush);
    pop            = clause_valid_o && clause_ready_i;
    occ_after      = occ_q - {1'b0, pop};
    // Entries held after this cycle's pop plus the one still arriving from the tree.
    committed      = occ_after + {1'b0, inflight_q};
    fifo_rden_o    = ((state_q == StDrain) && !fifo_empty_i && (committed < 2'd2)) ||
                     ((state_q == StFlush) && !fifo_empty_i);
    // A write_done arriving this cycle already counts toward the quiet run.
    wd_eff         = wd_seen_q ||
                     (write_done_i && ((state_q == StDrain) || (state_q == StFlush)));
    quiet_cond     = wd_eff && fifo_empty_i && !inflight_q;
    settled        = quiet_cond && (quiet_q == QuietLast);
    quiet_inc      = (quiet_q == QuietMax) ? quiet_q : quiet_q + 1'b1;
  end

  // Next state for the skid buffer, the counters and the batch FSM.
  always_comb begin
    state_d      = state_q;
    occ_d        = occ_after;
    head_d       = head_q;
    tail_d       = tail_q;
    inflight_d   = fifo_rden_o && !fifo_empty_i;
    count_d      = (pop && (count_q != '1)) ? count_q + 1'b1 : count_q;
    wd_seen_d    = wd_seen_q;
    quiet_d      = quiet_q;
    batch_done_o = 1'b0;
    sat_o        = 1'b0;
    overflow_o   = 1'b0;
    fifo_cof_o   = 1'b0;

    if (pop && (occ_q == 2'd2)) head_d = tail_q;
    // Read data lands at the tail, after any pop from the head in the same cycle.
    if (inflight_q && (state_q != StFlush)) begin
      if (occ_after == 2'd0) head_d = fifo_clause_i;
      else                   tail_d = fifo_clause_i;
      occ_d = occ_after + 2'd1;
    end

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StDrain;
          count_d   = '0;
          wd_seen_d = write_done_i;
          quiet_d   = '0;
        end
      end
      StDrain: begin
        wd_seen_d = wd_eff;
        quiet_d   = quiet_cond ? quiet_inc : '0;
        if (fifo_of_i)    state_d = StFlush;
        else if (settled) state_d = StFinish;
      end
      StFinish: begin
        if (occ_after == 2'd0) begin
          state_d      = StIdle;
          batch_done_o = 1'b1;
          sat_o        = (count_d == '0);
        end
      end
      default: begin
        occ_d     = 2'd0;
        wd_seen_d = wd_eff;
        quiet_d   = quiet_cond ? quiet_inc : '0;
        if (settled) begin
          state_d      = StIdle;
          fifo_cof_o   = 1'b1;
          batch_done_o = 1'b1;
          overflow_o   = 1'b1;
        end
      end
    endcase
  end

  // State registers; asynchronous reset abandons any batch in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      occ_q      <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wd_seen_q  <= 1'b0;
      quiet_q    <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wd_seen_q  <= wd_seen_d;
      quiet_q    <= quiet_d;
    end
  end

endmodule

// File: tb/tb_fifo_tree_drain.sv
// Self-checking bench for fifo_tree_drain: a queue-based tree model feeds the
// DUT, and a scoreboard checks delivery order, the buffer bound and batch results.
module tb_fifo_tree_drain;
  localparam int unsigned CW     = 36;
  localparam int unsigned NW     = 10;
  localparam int unsigned SETTLE = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i, write_done_i, fifo_empty_i, fifo_of_i, clause_ready_i;
  logic [CW-1:0] fifo_clause_i;
  logic          fifo_rden_o, fifo_cof_o, clause_valid_o, batch_done_o, sat_o, overflow_o;
  logic [CW-1:0] clause_o;
  logic [NW-1:0] unsat_count_o;

  always #5 clk = ~clk;

  fifo_tree_drain #(
    .CLAUSE_WIDTH (CW),
    .COUNT_WIDTH  (NW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start_i       (start_i),
    .write_done_i  (write_done_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_clause_i (fifo_clause_i),
    .fifo_of_i     (fifo_of_i),
    .fifo_rden_o   (fifo_rden_o),
    .fifo_cof_o    (fifo_cof_o),
    .clause_o      (clause_o),
    .clause_valid_o(clause_valid_o),
    .clause_ready_i(clause_ready_i),
    .batch_done_o  (batch_done_o),
    .unsat_count_o (unsat_count_o),
    .sat_o         (sat_o),
    .overflow_o    (overflow_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [CW-1:0] tree_q[$];
  logic [CW-1:0] exp_q[$];
  int   pop_cyc[$];
  int   outstanding = 0;  // clauses read from the tree but not yet delivered
  bit   inflight_m = 0;
  bit   wd_seen_m = 0;
  int   qrun = 0;
  int   due_cyc = -1;
  bit   flushing = 0;
  bit   done_flag = 0;
  int   done_cyc = 0;
  logic done_sat, done_over, done_cof;
  int   cof_cnt = 0;
  logic s_rden;
  int   s, wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] rnd_clause();
    logic [CW-1:0] r;
    r = {4'($urandom()), $urandom()};
    return r;
  endfunction

  task automatic push(input logic [CW-1:0] x);
    tree_q.push_back(x);
    exp_q.push_back(x);
    fifo_empty_i = 1'b0;
  endtask

  // One clock cycle: check outputs at the negedge, then advance the tree model after the posedge.
  task automatic tick();
    bit pop, acc, cond, cof;
    @(negedge clk);
    s_rden = fifo_rden_o;
    pop    = clause_valid_o && clause_ready_i;
    acc    = fifo_rden_o && !fifo_empty_i;
    cof    = fifo_cof_o;
    if (!flushing) begin
      chk("valid_vs_model", {63'd0, clause_valid_o}, {63'd0, (outstanding - inflight_m) > 0});
      if (pop) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("spurious_pop", 64'd1, 64'd0);
        else chk("clause_order", {28'd0, clause_o}, {28'd0, exp_q.pop_front()});
      end
      if (acc) chk("skid_overfill", {63'd0, (outstanding - pop) < 2}, 64'd1);
    end else begin
      chk("flush_valid_low", {63'd0, clause_valid_o}, 64'd0);
    end
    if (cof) cof_cnt++;
    if (batch_done_o) begin
      done_flag = 1;
      done_cyc  = cyc;
      done_sat  = sat_o;
      done_over = overflow_o;
      done_cof  = fifo_cof_o;
    end
    cond = (wd_seen_m || write_done_i) && fifo_empty_i && !inflight_m;
    if (start_i) begin
      wd_seen_m = write_done_i;
      qrun      = 0;
    end else begin
      qrun = cond ? qrun + 1 : 0;
      if (qrun == SETTLE) due_cyc = cyc + 1;
      if (write_done_i) wd_seen_m = 1;
    end
    if (batch_done_o) wd_seen_m = 0;
    @(posedge clk);
    #1;
    if (!flushing) outstanding = outstanding + int'(acc) - int'(pop);
    inflight_m = acc;
    if (acc) fifo_clause_i = tree_q.pop_front();
    else     fifo_clause_i = rnd_clause();
    fifo_empty_i = (tree_q.size() == 0);
    if (cof) fifo_of_i = 1'b0;
    start_i      = 1'b0;
    write_done_i = 1'b0;
    cyc++;
  endtask

  task automatic run_until_done(input int limit);
    for (int i = 0; i < limit && !done_flag; i++) tick();
    if (!done_flag) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic begin_batch();
    done_flag = 0;
    pop_cyc.delete();
    s = cyc;
    start_i = 1'b1;
    tick();
    wd = cyc;
    write_done_i = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    start_i = 0; write_done_i = 0; fifo_of_i = 0; clause_ready_i = 0;
    fifo_empty_i = 1'b1;
    fifo_clause_i = '0;
    tick();
    tick();
    chk("reset_ctrl", {58'd0, fifo_rden_o, fifo_cof_o, clause_valid_o, batch_done_o, sat_o,
        overflow_o}, 64'd0);
    chk("reset_clause", {28'd0, clause_o}, 64'd0);
    chk("reset_count", {54'd0, unsat_count_o}, 64'd0);
    reset = 1'b1;
    tick();

    // Basic: three clauses at full rate.
    for (int i = 0; i < 3; i++) push(rnd_clause());
    clause_ready_i = 1'b1;
    tick();
    chk("idle_no_read", {63'd0, s_rden}, 64'd0);
    begin_batch();
    run_until_done(60);
    if (pop_cyc.size() != 3) chk("basic_npops", 64'(pop_cyc.size()), 64'd3);
    else for (int i = 0; i < 3; i++) chk("basic_pop_cycle", 64'(pop_cyc[i]), 64'(s + 3 + i));
    chk("basic_done_time", 64'(done_cyc), 64'(due_cyc));
    chk("basic_sat", {63'd0, done_sat}, 64'd0);
    chk("basic_over", {63'd0, done_over}, 64'd0);
    tick();
    chk("basic_count", {54'd0, unsat_count_o}, 64'd3);
    chk("basic_sb_empty", 64'(exp_q.size()), 64'd0);

    // Empty batch: done exactly SETTLE cycles after write_done.
    begin_batch();
    run_until_done(40);
    chk("empty_done_time", 64'(done_cyc), 64'(wd + SETTLE));
    chk("empty_sat", {63'd0, done_sat}, 64'd1);
    chk("empty_cof", {63'd0, done_cof}, 64'd0);
    tick();
    chk("empty_count", {54'd0, unsat_count_o}, 64'd0);

    // Backpressure: ready follows a fixed toggling pattern.
    begin
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 5; i++) push(rnd_clause());
      begin_batch();
      for (int i = 0; i < 120 && !done_flag; i++) begin
        clause_ready_i = pat[i % 7];
        tick();
      end
      if (!done_flag) chk("bp_done_timeout", 64'd0, 64'd1);
      chk("bp_sat", {63'd0, done_sat}, 64'd0);
      clause_ready_i = 1'b1;
      tick();
      chk("bp_count", {54'd0, unsat_count_o}, 64'd5);
      chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    end

    // Late arrivals after a short quiet gap.
    clause_ready_i = 1'b1;
    push(rnd_clause());
    push(rnd_clause());
    begin_batch();
    for (int i = 0; i < 20 && (tree_q.size() > 0 || outstanding > 0); i++) tick();
    repeat (5) tick();
    chk("late_no_early_done", {63'd0, done_flag}, 64'd0);
    push(rnd_clause());
    push(rnd_clause());
    run_until_done(60);
    chk("late_done_time", 64'(done_cyc), 64'(due_cyc));
    tick();
    chk("late_count", {54'd0, unsat_count_o}, 64'd4);
    chk("late_sb_empty", 64'(exp_q.size()), 64'd0);

    // Overflow with two clauses buffered and four left in the tree.
    clause_ready_i = 1'b0;
    cof_cnt = 0;
    for (int i = 0; i < 6; i++) push(rnd_clause());
    begin_batch();
    tick();
    tick();
    chk("of_pre_valid", {63'd0, clause_valid_o}, 64'd1);
    fifo_of_i = 1'b1;
    tick();
    flushing = 1;
    clause_ready_i = 1'b1;
    run_until_done(60);
    chk("of_cof_with_done", {63'd0, done_cof}, 64'd1);
    chk("of_over", {63'd0, done_over}, 64'd1);
    chk("of_sat", {63'd0, done_sat}, 64'd0);
    tick();
    chk("of_cof_pulses", 64'(cof_cnt), 64'd1);
    chk("of_tree_drained", 64'(tree_q.size()), 64'd0);
    chk("of_count", {54'd0, unsat_count_o}, 64'd0);
    flushing = 0;
    exp_q.delete();
    outstanding = 0;

    // Asynchronous reset in the middle of DRAIN with a full buffer.
    clause_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(rnd_clause());
    begin_batch();
    tick();
    tick();
    chk("pre_reset_valid", {63'd0, clause_valid_o}, 64'd1);
    done_flag = 0;
    #2 reset = 1'b0;
    #1;
    chk("async_ctrl", {58'd0, fifo_rden_o, fifo_cof_o, clause_valid_o, batch_done_o, sat_o,
        overflow_o}, 64'd0);
    chk("async_clause", {28'd0, clause_o}, 64'd0);
    chk("async_count", {54'd0, unsat_count_o}, 64'd0);
    reset = 1'b1;
    tree_q.delete();
    exp_q.delete();
    fifo_empty_i = 1'b1;
    outstanding = 0;
    inflight_m = 0;
    wd_seen_m = 0;
    qrun = 0;
    tick();
    chk("reset_no_done", {63'd0, done_flag}, 64'd0);

    // Clean batch after reset.
    clause_ready_i = 1'b1;
    push(rnd_clause());
    push(rnd_clause());
    begin_batch();
    run_until_done(60);
    chk("post_done_time", 64'(done_cyc), 64'(due_cyc));
    chk("post_over", {63'd0, done_over}, 64'd0);
    tick();
    chk("post_count", {54'd0, unsat_count_o}, 64'd2);
    chk("post_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
